// File: rtl/gbt_pkg.sv
`default_nettype none
// ============================================================================
// gbt_pkg : shared types and constants for the GBTx return-link controller
// Rev 1.0 : initial release
// ============================================================================
package gbt_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LOSS_CNT_W = 8;
  localparam logic [DATA_W-1:0] IDLE_WORD_DEF = 16'hBC5C;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_TRAIN     = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } gbt_state_e;

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (v == '1) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gbt_lock_sync.sv
`default_nettype none
// ============================================================================
// gbt_lock_sync : two-flop RXRDY/RXDATAVALID synchronizer plus lock qualifier
// Rev 1.0 : initial release
// ============================================================================
module gbt_lock_sync #(
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxrdy_a,
  input  logic rxdv_a,
  input  logic cnt_en,
  output logic lock_raw,
  output logic lock_qual
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic [1:0]       rxrdy_q, rxrdy_d;
  logic [1:0]       rxdv_q, rxdv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rxrdy_d   = {rxrdy_q[0], rxrdy_a};
    rxdv_d    = {rxdv_q[0], rxdv_a};
    lock_raw  = rxrdy_q[1] && rxdv_q[1];
    lock_qual = cnt_en && lock_raw && (cnt_q == CNT_LAST);
    // Any gap in lock, or leaving the counting state, restarts qualification
    cnt_d     = (cnt_en && lock_raw) ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxrdy_q <= '0;
      rxdv_q  <= '0;
      cnt_q   <= '0;
    end else begin
      rxrdy_q <= rxrdy_d;
      rxdv_q  <= rxdv_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gbt_link_ctrl.sv
`default_nettype none
// ============================================================================
// gbt_link_ctrl : GBTx return-link bring-up FSM and DAQ/test-pattern arbiter
// Rev 1.0 : initial release
// ============================================================================
module gbt_link_ctrl
  import gbt_pkg::*;
#(
  parameter int unsigned       LOCK_CYCLES  = 1024,
  parameter int unsigned       TRAIN_FRAMES = 16,
  parameter logic [DATA_W-1:0] IDLE_WORD    = IDLE_WORD_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  GBT_RXRDY,
  input  logic                  GBT_RXDATAVALID,
  input  logic                  LINK_ENA,
  input  logic                  TEST_REQ,
  input  logic [DATA_W-1:0]     DAQ_DATA,
  input  logic                  DAQ_VALID,
  output logic                  DAQ_READY,
  output logic [DATA_W-1:0]     GBT_DATA_OUT,
  output logic                  GBT_ENA_TEST,
  output logic                  LINK_UP,
  output logic                  TEST_ACTIVE,
  output logic [LOSS_CNT_W-1:0] LOSS_CNT,
  output logic [2:0]            STATE
);

  localparam int unsigned TRAIN_W = $clog2(TRAIN_FRAMES + 1);
  localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(TRAIN_FRAMES - 1);

  gbt_state_e            state_q, state_d;
  logic [TRAIN_W-1:0]    train_cnt_q, train_cnt_d;
  logic [DATA_W-1:0]     pat_q, pat_d;
  logic                  grant_q, grant_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  ena_test_q, ena_test_d;
  logic                  link_up_q, link_up_d;
  logic                  test_active_q, test_active_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  logic                  cnt_en;
  logic                  lock_raw;
  logic                  lock_qual;
  logic                  stay_run;
  logic                  daq_ready;
  logic [DATA_W-1:0]     pat_cur;

  gbt_lock_sync #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_sync (
    .clk       (CLK),
    .rst_n     (RST_N),
    .rxrdy_a   (GBT_RXRDY),
    .rxdv_a    (GBT_RXDATAVALID),
    .cnt_en    (cnt_en),
    .lock_raw  (lock_raw),
    .lock_qual (lock_qual)
  );

  assign cnt_en = (state_q == ST_WAIT_LOCK);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_qual) state_d = ST_TRAIN;
      ST_TRAIN: begin
        if (!lock_raw)                       state_d = ST_LOST;
        else if (train_cnt_q == TRAIN_LAST) state_d = ST_RUN;
      end
      ST_RUN:       if (!lock_raw) state_d = ST_LOST;
      ST_LOST:      state_d = ST_WAIT_LOCK;
      default:      state_d = ST_IDLE;
    endcase
    // Disabling the link wins over everything, including lock loss
    if (!LINK_ENA) state_d = ST_IDLE;
  end

  always_comb begin
    train_cnt_d = '0;
    if (state_q == ST_TRAIN && state_d == ST_TRAIN) train_cnt_d = train_cnt_q + TRAIN_W'(1);

    stay_run  = (state_q == ST_RUN) && (state_d == ST_RUN);
    daq_ready = (state_q == ST_RUN) && !grant_q;
    // Grant waits for an idle DAQ cycle, then holds while TEST_REQ stays high
    grant_d   = stay_run && TEST_REQ && (grant_q || !DAQ_VALID);
    pat_cur   = grant_q ? pat_q : '0;
    pat_d     = grant_d ? pat_cur + DATA_W'(1) : '0;

    data_d = '0;
    case (state_d)
      ST_TRAIN: data_d = IDLE_WORD;
      ST_RUN: begin
        if (grant_d)                     data_d = pat_cur;
        else if (daq_ready && DAQ_VALID) data_d = DAQ_DATA;
        else                             data_d = IDLE_WORD;
      end
      default:  data_d = '0;
    endcase

    ena_test_d    = (state_d == ST_TRAIN) || (state_d == ST_RUN);
    link_up_d     = (state_d == ST_RUN);
    test_active_d = grant_d;
    loss_d        = (state_d == ST_LOST) ? sat_inc(loss_q) : loss_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      train_cnt_q   <= '0;
      pat_q         <= '0;
      grant_q       <= 1'b0;
      data_q        <= '0;
      ena_test_q    <= 1'b0;
      link_up_q     <= 1'b0;
      test_active_q <= 1'b0;
      loss_q        <= '0;
    end else begin
      state_q       <= state_d;
      train_cnt_q   <= train_cnt_d;
      pat_q         <= pat_d;
      grant_q       <= grant_d;
      data_q        <= data_d;
      ena_test_q    <= ena_test_d;
      link_up_q     <= link_up_d;
      test_active_q <= test_active_d;
      loss_q        <= loss_d;
    end
  end

  assign DAQ_READY    = daq_ready;
  assign GBT_DATA_OUT = data_q;
  assign GBT_ENA_TEST = ena_test_q;
  assign LINK_UP      = link_up_q;
  assign TEST_ACTIVE  = test_active_q;
  assign LOSS_CNT     = loss_q;
  assign STATE        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_gbt_link_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gbt_link_ctrl : directed self-checking bench for gbt_link_ctrl
// Rev 1.0 : initial release
// ============================================================================
module tb_gbt_link_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rxrdy;
  logic        rxdv;
  logic        link_ena;
  logic        test_req;
  logic [15:0] daq_data;
  logic        daq_valid;
  logic        daq_ready;
  logic [15:0] data_out;
  logic        ena_test;
  logic        link_up;
  logic        test_active;
  logic [7:0]  loss_cnt;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  gbt_link_ctrl #(
    .LOCK_CYCLES  (8),
    .TRAIN_FRAMES (4)
  ) dut (
    .CLK             (clk),
    .RST_N           (rst_n),
    .GBT_RXRDY       (rxrdy),
    .GBT_RXDATAVALID (rxdv),
    .LINK_ENA        (link_ena),
    .TEST_REQ        (test_req),
    .DAQ_DATA        (daq_data),
    .DAQ_VALID       (daq_valid),
    .DAQ_READY       (daq_ready),
    .GBT_DATA_OUT    (data_out),
    .GBT_ENA_TEST    (ena_test),
    .LINK_UP         (link_up),
    .TEST_ACTIVE     (test_active),
    .LOSS_CNT        (loss_cnt),
    .STATE           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n = 0;
    while (state !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rxrdy = 1'b0; rxdv = 1'b0; link_ena = 1'b0;
    test_req = 1'b0; daq_data = 16'h0; daq_valid = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_ena_test", 32'(ena_test), 32'd0);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_test_active", 32'(test_active), 32'd0);
    check("rst_loss", 32'(loss_cnt), 32'd0);
    check("rst_ready", 32'(daq_ready), 32'd0);

    rst_n = 1'b1;
    tick();
    check("idle_hold", 32'(state), 32'd0);

    // Bring-up: synchronizer (2) + 8 lock cycles
    link_ena = 1'b1; rxrdy = 1'b1; rxdv = 1'b1;
    tick();
    check("wait_data", 32'(data_out), 32'h0);
    check("bringup_wait", 32'(state), 32'd1);
    for (int i = 1; i < 9; i++) begin
      tick();
      check("bringup_wait", 32'(state), 32'd1);
    end
    tick();
    check("bringup_train", 32'(state), 32'd2);
    check("train_data", 32'(data_out), 32'hBC5C);
    check("train_ena", 32'(ena_test), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("train_hold", 32'(state), 32'd2);
      check("train_data", 32'(data_out), 32'hBC5C);
    end
    tick();
    check("run_state", 32'(state), 32'd3);
    check("run_link_up", 32'(link_up), 32'd1);
    check("run_first_data", 32'(data_out), 32'hBC5C);

    // DAQ path
    daq_valid = 1'b1; daq_data = 16'h1234;
    check("daq_ready", 32'(daq_ready), 32'd1);
    tick();
    check("daq_1234", 32'(data_out), 32'h1234);
    daq_data = 16'hABCD;
    tick();
    check("daq_abcd", 32'(data_out), 32'hABCD);
    daq_valid = 1'b0;
    tick();
    check("daq_idle", 32'(data_out), 32'hBC5C);

    // Arbitration: DAQ keeps priority while valid
    test_req = 1'b1; daq_valid = 1'b1; daq_data = 16'h5555;
    tick();
    check("arb_daq_5555", 32'(data_out), 32'h5555);
    check("arb_no_grant", 32'(test_active), 32'd0);
    check("arb_ready", 32'(daq_ready), 32'd1);
    daq_data = 16'h6666;
    tick();
    check("arb_daq_6666", 32'(data_out), 32'h6666);
    daq_valid = 1'b0;
    tick();
    check("arb_grant", 32'(test_active), 32'd1);
    check("arb_pat0", 32'(data_out), 32'h0);
    check("arb_ready_low", 32'(daq_ready), 32'd0);
    daq_valid = 1'b1; daq_data = 16'h7777;
    tick();
    check("arb_pat1", 32'(data_out), 32'h1);
    tick();
    check("arb_pat2", 32'(data_out), 32'h2);
    test_req = 1'b0;
    tick();
    check("arb_release_ready", 32'(daq_ready), 32'd1);
    check("arb_release_ta", 32'(test_active), 32'd0);
    check("arb_release_data", 32'(data_out), 32'hBC5C);
    tick();
    check("arb_daq_7777", 32'(data_out), 32'h7777);
    daq_valid = 1'b0;

    // Lock loss in RUN; the word accepted in the loss cycle is suppressed
    rxdv = 1'b0;
    tick();
    tick();
    check("loss_still_run", 32'(state), 32'd3);
    daq_valid = 1'b1; daq_data = 16'h9999;
    tick();
    check("loss_state", 32'(state), 32'd4);
    check("loss_cnt1", 32'(loss_cnt), 32'd1);
    check("loss_ena_test", 32'(ena_test), 32'd0);
    check("loss_link_up", 32'(link_up), 32'd0);
    check("loss_data", 32'(data_out), 32'h0);
    rxdv = 1'b1; daq_valid = 1'b0;
    tick();
    check("loss_to_wait", 32'(state), 32'd1);

    // Glitch at lock count 5 restarts qualification
    repeat (6) tick();
    rxrdy = 1'b0;
    tick();
    rxrdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("glitch_wait", 32'(state), 32'd1);
    end
    tick();
    check("glitch_train", 32'(state), 32'd2);
    repeat (4) tick();
    check("glitch_run", 32'(state), 32'd3);

    // LINK_ENA=0 together with lock loss: IDLE, no loss counted
    rxdv = 1'b0;
    tick();
    tick();
    check("prec_run", 32'(state), 32'd3);
    link_ena = 1'b0;
    tick();
    check("prec_idle", 32'(state), 32'd0);
    check("prec_loss", 32'(loss_cnt), 32'd1);
    check("prec_data", 32'(data_out), 32'h0);
    link_ena = 1'b1; rxdv = 1'b1;
    wait_state("prec_reup", 3'd3, 40);

    // Saturation of the loss counter
    for (int i = 0; i < 256; i++) begin
      rxdv = 1'b0;
      wait_state("sat_lost", 3'd4, 30);
      rxdv = 1'b1;
      if (i == 252) check("sat_fe", 32'(loss_cnt), 32'hFE);
      wait_state("sat_run", 3'd3, 40);
    end
    check("sat_ff", 32'(loss_cnt), 32'hFF);

    // Reset mid-RUN with the test pattern active
    test_req = 1'b1; daq_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_ta", 32'(test_active), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_ena", 32'(ena_test), 32'd0);
    check("mid_rst_link", 32'(link_up), 32'd0);
    check("mid_rst_ta", 32'(test_active), 32'd0);
    check("mid_rst_loss", 32'(loss_cnt), 32'd0);
    check("mid_rst_ready", 32'(daq_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
